operand_register: RTL and testbench

Parameterised word-addressable operand store: MATRIX_SIZE words of DATA_WIDTH bits, one shared address for read and write. It holds matrix operand elements loaded over the host write path and read back by the datapath or host. Single clock domain; all storage is cleared by an asynchronous active-low reset.

---
 rtl/operand_register.sv | 96 +++++++++
 tb/tb_operand_register.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/operand_register.sv
// operand_register: word-addressable operand store of MATRIX_SIZE elements,
// each DATA_WIDTH bits wide. Read and write share one address. Every entry is
// cleared by an asynchronous active-low reset.
//
// Build option: define OPERAND_REG_RDREG_EN to register read_data_Mat_o.
// With the option, the output is registered, write-first and has 1 cycle of
// latency. Without it, the read is combinational. Storage behaves the same in
// both builds.
//
// Interface protocol: there is no handshake. write_en_Mat_i qualifies the
// write for the cycle in which it is high. Any address at or above
// MATRIX_SIZE is dropped on write and reads as 0, with no wrap-around.
module operand_register #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int MATRIX_SIZE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] write_data_Mat_i,
  input  logic [ADDR_WIDTH-1:0] addr_Mat_i,
  input  logic                  write_en_Mat_i,
  output logic [DATA_WIDTH-1:0] read_data_Mat_o
);

  // One extra bit so that MATRIX_SIZE == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0] SizeExt = (ADDR_WIDTH + 1)'(MATRIX_SIZE);

  logic [DATA_WIDTH-1:0] mem_q [MATRIX_SIZE];
  logic [DATA_WIDTH-1:0] mem_d [MATRIX_SIZE];
  logic                  addr_in_range;
  logic                  write_hit;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  // Decode the address range and qualify the write strobe.
  always_comb begin
    addr_in_range = ({1'b0, addr_Mat_i} < SizeExt);
    write_hit     = write_en_Mat_i && addr_in_range;
  end

  // Storage next state: only the addressed, in-range entry changes.
  always_comb begin
    mem_d = mem_q;
    if (write_hit) begin
      mem_d[addr_Mat_i] = write_data_Mat_i;
    end
  end

  // Storage register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MATRIX_SIZE; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Stored element at the current address, or 0 when the address is out of range.
  always_comb begin
    mem_rd_data = '0;
    if (addr_in_range) begin
      mem_rd_data = mem_q[addr_Mat_i];
    end
  end

`ifdef OPERAND_REG_RDREG_EN
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  // Read register next state. A same-edge write to the addressed entry is
  // forwarded so that the register shows the new value (write-first).
  always_comb begin
    rd_data_d = mem_rd_data;
    if (write_hit) begin
      rd_data_d = write_data_Mat_i;
    end
  end

  // Read output register, cleared asynchronously with the storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign read_data_Mat_o = rd_data_q;
`else
  // Combinational read. Storage is already 0 during reset, so the output is too.
  assign read_data_Mat_o = mem_rd_data;
`endif

endmodule

// File: tb/tb_operand_register.sv
// Directed testbench for operand_register. The instance uses MATRIX_SIZE=12,
// which leaves addresses 12..15 out of range. The read timing follows
// OPERAND_REG_RDREG_EN.
module tb_operand_register;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int MS = 12;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] wdata;
  logic [AW-1:0] addr;
  logic          we;
  logic [DW-1:0] rdata;

  int checks = 0;
  int errors = 0;

  operand_register #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MATRIX_SIZE(MS)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .write_data_Mat_i(wdata),
    .addr_Mat_i      (addr),
    .write_en_Mat_i  (we),
    .read_data_Mat_o (rdata)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write one element. The write is captured on the next rising edge.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  // Read one element and compare it with the expected value.
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    @(negedge clk);
    addr = a;
    we   = 1'b0;
`ifdef OPERAND_REG_RDREG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
    check(tag, rdata, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    we    = 1'b1;
    wdata = '0;
    addr  = '0;

    // Reset held: sweep all 16 addresses while write_en is high with data 0.
    repeat (2) @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      addr = AW'(i);
      #1;
      check($sformatf("reset_sweep_%0d", i), rdata, 32'h0);
    end

    // A write attempted during reset must not land.
    @(negedge clk);
    addr  = 4'd3;
    wdata = 32'h5555_5555;
    we    = 1'b1;
    @(posedge clk);
    #1;
    check("write_during_reset", rdata, 32'h0);
    we = 1'b0;

    // Release reset.
    @(negedge clk);
    rst_n = 1'b1;
    do_read(4'd3, 32'h0, "after_release_addr3");

    // Write 8 to addr 0. The other addresses still read 0.
    do_write(4'd0, 32'd8);
    do_read(4'd0, 32'd8, "addr0_eq_8");
    for (int i = 1; i < MS; i++) begin
      do_read(AW'(i), 32'h0, $sformatf("untouched_%0d", i));
    end

    // Write 88 to addr 2.
    do_write(4'd2, 32'd88);
    do_read(4'd2, 32'd88, "addr2_eq_88");
    do_read(4'd0, 32'd8,  "addr0_still_8");
    do_read(4'd1, 32'h0,  "addr1_still_0");

    // write_en low for 3 edges with new data on the bus.
    @(negedge clk);
    addr  = 4'd2;
    wdata = 32'h1234;
    we    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_read(4'd2, 32'd88, "no_write_when_en_low");

    // Boundary: the last valid address, then the first and a later invalid one.
    do_write(4'd11, 32'hBEEF);
    do_read(4'd11, 32'hBEEF, "last_valid_addr");
    do_write(4'd13, 32'hDEAD);
    do_read(4'd13, 32'h0, "oob_13_reads_0");
    do_write(4'd12, 32'hCAFE);
    do_read(4'd12, 32'h0, "oob_12_reads_0");
    do_read(4'd15, 32'h0, "oob_15_reads_0");
    do_read(4'd0,  32'd8,     "no_alias_addr0");
    do_read(4'd1,  32'h0,     "no_alias_addr1");
    do_read(4'd2,  32'd88,    "no_alias_addr2");
    do_read(4'd4,  32'h0,     "no_alias_addr4");
    do_read(4'd5,  32'h0,     "no_alias_addr5");
    do_read(4'd11, 32'hBEEF,  "no_alias_addr11");

`ifdef OPERAND_REG_RDREG_EN
    // Write-first: a same-edge write is visible in the register right after the edge.
    @(negedge clk);
    addr  = 4'd2;
    wdata = 32'h99;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    check("rdreg_write_first", rdata, 32'h99);
    // 1-cycle latency: a new address does not show before the edge.
    @(negedge clk);
    addr = 4'd0;
    #1;
    check("rdreg_latency_hold", rdata, 32'h99);
    @(posedge clk);
    #1;
    check("rdreg_latency_load", rdata, 32'd8);
    do_read(4'd2, 32'h99, "rdreg_addr2_stored");
`else
    // Combinational read: the old value shows before the write edge, the new one after.
    @(negedge clk);
    addr  = 4'd2;
    wdata = 32'h77;
    we    = 1'b1;
    #1;
    check("comb_old_before_edge", rdata, 32'd88);
    @(posedge clk);
    #1;
    we = 1'b0;
    check("comb_new_after_edge", rdata, 32'h77);
    // Zero-latency address change.
    @(negedge clk);
    addr = 4'd0;
    #1;
    check("comb_addr_change", rdata, 32'd8);
`endif

    // Assert reset mid-sequence: the output clears before any clock edge.
    @(negedge clk);
    addr  = 4'd0;
    rst_n = 1'b0;
    #1;
    check("async_reset_addr0", rdata, 32'h0);
    addr = 4'd2;
    #1;
    check("async_reset_addr2", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_read(4'd2,  32'h0, "post_reset_addr2");
    do_read(4'd11, 32'h0, "post_reset_addr11");

    // The first write after release takes effect.
    do_write(4'd5, 32'hA5A5_0001);
    do_read(4'd5, 32'hA5A5_0001, "post_reset_write");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
